// File: rtl/spi_slave_if.sv
// Pin and local-handshake bundle for spi_slave: SPI pins on one side,
// tx_load/tx_ready and rx_valid/rx_ack word exchange plus status on the other.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             ss_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic             busy;
  logic             rx_overrun;
  logic             tx_underrun;
  logic             clr_err;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_load, rx_ack, clr_err,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_load, rx_ack, clr_err,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, fully oversampled on clk. Pins pass through
// SYNC_STAGES-deep synchronizers plus one edge-detect register each.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  state_e           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] tx_buf_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-2:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic             miso_oe_q;
  logic             busy_q;
  logic             rx_overrun_q;
  logic             tx_underrun_q;

  logic             sclk_s;
  logic             ss_s;
  logic             mosi_s;
  logic             sclk_rise_s;
  logic             sclk_fall_s;
  logic             ss_rise_s;
  logic             ss_fall_s;
  logic             frame_start_s;
  logic             frame_end_s;
  logic             bit_in_s;
  logic             word_done_s;
  logic             shift_out_s;
  logic             reload_s;
  logic             underrun_evt_s;
  logic             overrun_evt_s;
  logic [WIDTH-1:0] reload_word_d;
  logic [WIDTH-1:0] rx_word_d;
  logic [WIDTH-1:0] tx_shift_d;
  logic [CW-1:0]    bit_cnt_d;

  // Edge detection and per-cycle event decode.
  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise_s = sclk_s & ~sclk_prev_q;
    sclk_fall_s = ~sclk_s & sclk_prev_q;
    ss_rise_s   = ss_s & ~ss_prev_q;
    ss_fall_s   = ~ss_s & ss_prev_q;

    frame_start_s = (state_q == IDLE) && ss_fall_s;
    frame_end_s   = (state_q == ACTIVE) && ss_rise_s;
    // Frame end outranks an sclk edge seen in the same cycle.
    bit_in_s      = (state_q == ACTIVE) && !ss_rise_s && sclk_rise_s;
    shift_out_s   = (state_q == ACTIVE) && !ss_rise_s && sclk_fall_s;
    word_done_s   = bit_in_s && (bit_cnt_q == LAST_BIT);
    reload_s      = frame_start_s || (shift_out_s && (bit_cnt_q == {CW{1'b0}}));

    underrun_evt_s = reload_s && tx_ready_q;
    overrun_evt_s  = word_done_s && rx_valid_q && !bus.rx_ack;

    if (tx_ready_q) begin
      reload_word_d = {WIDTH{1'b0}};
    end else begin
      reload_word_d = tx_buf_q;
    end

    if (reload_s) begin
      tx_shift_d = reload_word_d;
    end else begin
      tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
    end

    if (bit_cnt_q == LAST_BIT) begin
      bit_cnt_d = {CW{1'b0}};
    end else begin
      bit_cnt_d = bit_cnt_q + CW'(1);
    end

    rx_word_d = {rx_shift_q, mosi_s};
  end

  // Synchronizers, handshakes, sticky flags and the IDLE/ACTIVE state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      // ss chain resets low so a select already held low at release is not seen as a fall.
      sclk_sync_q   <= {SYNC_STAGES{1'b0}};
      ss_sync_q     <= {SYNC_STAGES{1'b0}};
      mosi_sync_q   <= {SYNC_STAGES{1'b0}};
      sclk_prev_q   <= 1'b0;
      ss_prev_q     <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= {CW{1'b0}};
      tx_buf_q      <= {WIDTH{1'b0}};
      tx_shift_q    <= {WIDTH{1'b0}};
      rx_shift_q    <= {(WIDTH-1){1'b0}};
      rx_data_q     <= {WIDTH{1'b0}};
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;

      // A reload only consumes a full buffer and a load only fills an empty one.
      if (bus.tx_load && tx_ready_q) begin
        tx_buf_q   <= bus.tx_data;
        tx_ready_q <= 1'b0;
      end else if (reload_s && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end

      if (word_done_s) begin
        rx_data_q  <= rx_word_d;
        rx_valid_q <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end

      if (overrun_evt_s) begin
        rx_overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        rx_overrun_q <= 1'b0;
      end

      if (underrun_evt_s) begin
        tx_underrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        tx_underrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (frame_start_s) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= {CW{1'b0}};
            tx_shift_q <= tx_shift_d;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_end_s) begin
            state_q    <= IDLE;
            bit_cnt_q  <= {CW{1'b0}};
            tx_shift_q <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
          end else begin
            if (bit_in_s) begin
              rx_shift_q <= rx_word_d[WIDTH-2:0];
              bit_cnt_q  <= bit_cnt_d;
            end
            if (shift_out_s) begin
              tx_shift_q <= tx_shift_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso        = tx_shift_q[WIDTH-1];
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = busy_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as a mode-0 master at clk/8 and checks against a
// word-level model of the tx buffer, rx register and sticky flags.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic         m_full;
  logic [W-1:0] m_buf;
  logic         m_valid;
  logic [W-1:0] m_rdata;
  logic         m_orun;
  logic         m_urun;

  int           f_words;
  int           f_abort;
  logic         f_ack_done;
  logic         f_clr_entry;
  logic [W-1:0] f_mosi   [4];
  logic         f_ld_en  [4];
  logic [W-1:0] f_ld_val [4];
  logic         f_ack_en [4];
  logic [W-1:0] exp_tx   [4];
  logic [W-1:0] got_tx   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic m_reset();
    m_full = 1'b0; m_buf = '0; m_valid = 1'b0; m_rdata = '0; m_orun = 1'b0; m_urun = 1'b0;
  endtask

  // Every word start takes the buffered word, or sends zeros and flags an underrun.
  task automatic m_boundary(input int w);
    if (m_full) begin
      exp_tx[w] = m_buf;
      m_full    = 1'b0;
    end else begin
      exp_tx[w] = '0;
      m_urun    = 1'b1;
    end
  endtask

  task automatic m_complete(input logic [W-1:0] word, input logic ack_same);
    if (m_valid && !ack_same) m_orun = 1'b1;
    m_valid = 1'b1;
    m_rdata = word;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    chk("tx_ready_pre_load", bus.tx_ready, !m_full);
    bus.tx_data = v; bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
  endtask

  task automatic do_ack();
    chk("rx_data_pre_ack", bus.rx_data, m_rdata);
    bus.rx_ack = 1'b1;
    tick(1);
    bus.rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    m_orun = 1'b0; m_urun = 1'b0;
  endtask

  task automatic clear_plan();
    f_words = 1; f_abort = 0; f_ack_done = 1'b0; f_clr_entry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = '0; f_ld_en[i] = 1'b0; f_ld_val[i] = '0; f_ack_en[i] = 1'b0;
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_miso"}, bus.miso, 1'b0);
    chk({tag, "_miso_oe"}, bus.miso_oe, 1'b0);
    chk({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    chk({tag, "_rx_data"}, bus.rx_data, '0);
    chk({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rx_overrun"}, bus.rx_overrun, 1'b0);
    chk({tag, "_tx_underrun"}, bus.tx_underrun, 1'b0);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_rx_valid"}, bus.rx_valid, m_valid);
    chk({tag, "_rx_data"}, bus.rx_data, m_rdata);
    chk({tag, "_rx_overrun"}, bus.rx_overrun, m_orun);
    chk({tag, "_tx_underrun"}, bus.tx_underrun, m_urun);
    chk({tag, "_tx_ready"}, bus.tx_ready, !m_full);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_miso_oe"}, bus.miso_oe, 1'b0);
    chk({tag, "_miso"}, bus.miso, 1'b0);
  endtask

  // Final sclk fall coincides with ss_n rise, so no trailing word boundary occurs.
  task automatic run_frame(input string tag);
    int  bits_done;
    int  used;
    logic last;
    bits_done = 0;
    for (int i = 0; i < 4; i++) got_tx[i] = '0;
    bus.sclk = 1'b0; bus.ss_n = 1'b0; bus.mosi = f_mosi[0][W-1];
    m_boundary(0);
    if (f_clr_entry) begin
      tick(LAT - 1);
      bus.clr_err = 1'b1;
      tick(1);
      bus.clr_err = 1'b0;
      tick(HALF - LAT);
    end else begin
      tick(HALF);
    end
    chk({tag, "_busy_active"}, bus.busy, 1'b1);
    chk({tag, "_oe_active"}, bus.miso_oe, 1'b1);
    for (int w = 0; w < f_words; w++) begin
      for (int b = W - 1; b >= 0; b--) begin
        got_tx[w][b] = bus.miso;
        bus.sclk = 1'b1;
        last = (w == f_words - 1) && (b == 0);
        bits_done++;
        if (last && f_ack_done) begin
          tick(LAT - 1);
          bus.rx_ack = 1'b1;
          tick(1);
          bus.rx_ack = 1'b0;
          m_complete(f_mosi[w], 1'b1);
          tick(HALF - LAT);
        end else begin
          tick(1);
          used = 1;
          if (b == 4 && f_ack_en[w]) begin do_ack(); used++; end
          if (b == 4 && f_ld_en[w]) begin do_load(f_ld_val[w]); used++; end
          tick(HALF - used);
          if (b == 0) m_complete(f_mosi[w], 1'b0);
        end
        if (f_abort != 0 && bits_done == f_abort) begin
          bus.sclk = 1'b0; bus.ss_n = 1'b1;
          tick(HALF + LAT);
          return;
        end
        if (last) begin
          bus.sclk = 1'b0; bus.ss_n = 1'b1;
        end else begin
          bus.sclk = 1'b0;
          if (b > 0) begin
            bus.mosi = f_mosi[w][b-1];
          end else begin
            bus.mosi = f_mosi[w+1][W-1];
            m_boundary(w + 1);
          end
        end
        tick(HALF);
      end
    end
    tick(LAT);
    for (int w = 0; w < f_words; w++) chk($sformatf("%s_miso_w%0d", tag, w), got_tx[w], exp_tx[w]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_load = 1'b0; bus.rx_ack = 1'b0; bus.clr_err = 1'b0;
    m_reset();
    tick(5);
    reset_check("reset");
    rst = 1'b0;
    tick(5);

    // Single word.
    clear_plan();
    do_load(8'hA5);
    chk("single_tx_ready_after_load", bus.tx_ready, 1'b0);
    f_mosi[0] = 8'h3C;
    run_frame("single");
    chk("single_miso_word", got_tx[0], 8'hA5);
    chk("single_rx_data", bus.rx_data, 8'h3C);
    idle_check("single");
    tick(10);
    chk("single_rx_valid_held", bus.rx_valid, 1'b1);
    do_ack();
    chk("single_rx_valid_acked", bus.rx_valid, 1'b0);

    // Back-to-back words in one frame.
    clear_plan();
    do_load(8'h11);
    f_words = 2; f_mosi[0] = 8'h81; f_mosi[1] = 8'h7E;
    f_ld_en[0] = 1'b1; f_ld_val[0] = 8'h22; f_ack_en[1] = 1'b1;
    run_frame("b2b");
    chk("b2b_miso_w0", got_tx[0], 8'h11);
    chk("b2b_miso_w1", got_tx[1], 8'h22);
    chk("b2b_rx_data", bus.rx_data, 8'h7E);
    chk("b2b_no_overrun", bus.rx_overrun, 1'b0);
    chk("b2b_no_underrun", bus.tx_underrun, 1'b0);
    idle_check("b2b");
    do_ack();

    // Underrun, clr_err, then clr_err colliding with a fresh underrun.
    clear_plan();
    f_mosi[0] = 8'h5A;
    run_frame("urun");
    chk("urun_miso_zero", got_tx[0], 8'h00);
    chk("urun_flag", bus.tx_underrun, 1'b1);
    idle_check("urun");
    do_clr();
    chk("urun_cleared", bus.tx_underrun, 1'b0);
    do_ack();
    clear_plan();
    f_clr_entry = 1'b1; f_mosi[0] = 8'hC3;
    run_frame("urun_clr");
    chk("urun_clr_event_wins", bus.tx_underrun, 1'b1);
    idle_check("urun_clr");
    do_clr();
    do_ack();

    // Overrun, then ack landing in the completion cycle.
    clear_plan();
    do_load(8'h5A);
    f_words = 2; f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
    f_ld_en[0] = 1'b1; f_ld_val[0] = 8'h6B;
    run_frame("orun");
    chk("orun_flag", bus.rx_overrun, 1'b1);
    chk("orun_rx_data", bus.rx_data, 8'h34);
    idle_check("orun");
    do_clr();
    do_ack();
    clear_plan();
    do_load(8'h96);
    f_words = 2; f_mosi[0] = 8'hE1; f_mosi[1] = 8'h1E;
    f_ld_en[0] = 1'b1; f_ld_val[0] = 8'h69; f_ack_done = 1'b1;
    run_frame("ackdone");
    chk("ackdone_rx_valid", bus.rx_valid, 1'b1);
    chk("ackdone_no_overrun", bus.rx_overrun, 1'b0);
    idle_check("ackdone");
    do_ack();

    // Abort after 5 bits, then a clean frame.
    clear_plan();
    f_abort = 5; f_mosi[0] = 8'hFF;
    run_frame("abort");
    chk("abort_rx_valid", bus.rx_valid, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_miso_oe", bus.miso_oe, 1'b0);
    do_clr();
    clear_plan();
    do_load(8'hB7);
    f_mosi[0] = 8'h4D;
    run_frame("post_abort");
    chk("post_abort_rx_data", bus.rx_data, 8'h4D);
    idle_check("post_abort");
    do_ack();

    // Reset mid-frame: sclk activity before the next select is ignored.
    do_load(8'h3E);
    bus.ss_n = 1'b0; bus.mosi = 1'b1;
    tick(HALF);
    repeat (3) begin
      bus.sclk = 1'b1; tick(HALF);
      bus.sclk = 1'b0; tick(HALF);
    end
    rst = 1'b1;
    tick(3);
    reset_check("midrst");
    rst = 1'b0;
    m_reset();
    repeat (8) begin
      bus.mosi = 1'($urandom_range(1, 0));
      bus.sclk = 1'b1; tick(HALF);
      bus.sclk = 1'b0; tick(HALF);
    end
    chk("midrst_busy_ignored", bus.busy, 1'b0);
    chk("midrst_rx_valid_ignored", bus.rx_valid, 1'b0);
    bus.ss_n = 1'b1;
    tick(6);
    clear_plan();
    do_load(8'hD2);
    f_mosi[0] = 8'h2D;
    run_frame("post_rst");
    chk("post_rst_rx_data", bus.rx_data, 8'h2D);
    idle_check("post_rst");
    do_ack();

    // Randomized frames against the model.
    for (int it = 0; it < 25; it++) begin
      clear_plan();
      f_words = int'($urandom_range(3, 1));
      for (int i = 0; i < 4; i++) begin
        f_mosi[i]   = W'($urandom);
        f_ld_en[i]  = 1'($urandom_range(1, 0));
        f_ld_val[i] = W'($urandom);
        f_ack_en[i] = 1'($urandom_range(1, 0));
      end
      if ($urandom_range(3, 0) != 0) do_load(W'($urandom));
      run_frame($sformatf("rnd%0d", it));
      idle_check($sformatf("rnd%0d", it));
      if ($urandom_range(1, 0) == 1) do_ack();
      if ($urandom_range(2, 0) == 0) do_clr();
      tick(int'($urandom_range(6, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
